mod_addsub_pipe: RTL

- Pipelined, parametrised modular adder/subtractor: c_o = (a_i ± b_i) mod q_i, operation selected per transaction by op_i.
- Generalises the single-cycle combinational mod adder to W-bit operands, a subtract mode, a tag sideband and valid/ready flow control.
- Sits in the PE datapath between operand fetch and the butterfly/accumulate stages.
- Accepts one transaction per cycle when unstalled; result latency is 2 cycles.

---
 rtl/mod_arith_pkg.sv | 13 +
 rtl/subtractor_n.sv | 18 +
 rtl/mod_addsub_pipe.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mod_arith_pkg.sv
// mod_arith_pkg: shared operation encoding and modulus constants
// for the modular arithmetic datapath.
package mod_arith_pkg;

    typedef enum logic {
        MOD_OP_ADD = 1'b0,
        MOD_OP_SUB = 1'b1
    } mod_op_e;

    localparam int          Q_W_DEFAULT = 23;
    localparam logic [22:0] Q_DILITHIUM = 23'd8380417;

endpackage

// File: rtl/subtractor_n.sv
// subtractor_n: nb_bit-wide subtractor with explicit borrow out.
// diff_o = a_i - b_i mod 2^nb_bit; borrow_o set when a_i < b_i.
module subtractor_n #(
    parameter int nb_bit = 8
) (
    input  logic [nb_bit-1:0] a_i,
    input  logic [nb_bit-1:0] b_i,
    output logic [nb_bit-1:0] diff_o,
    output logic              borrow_o
);

    logic [nb_bit:0] full;

    assign full     = {1'b0, a_i} - {1'b0, b_i};
    assign diff_o   = full[nb_bit-1:0];
    assign borrow_o = full[nb_bit];

endmodule

// File: rtl/mod_addsub_pipe.sv
// mod_addsub_pipe: 2-stage modular add/sub, c = (a +/- b) mod q.
// Define MOD_ADDSUB_RANGE_CHK_EN to flag operands outside [0, q) on err_o.
module mod_addsub_pipe
    import mod_arith_pkg::*;
#(
    parameter int W     = Q_W_DEFAULT,
    parameter int TAG_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  mod_op_e          op_i,
    input  logic [W-1:0]     a_i,
    input  logic [W-1:0]     b_i,
    input  logic [W-1:0]     q_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [W-1:0]     c_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             err_o
);

    logic             s1_valid_q, s1_valid_d;
    logic [W:0]       s1_raw_q, s1_raw_d;
    logic [W-1:0]     s1_mod_q, s1_mod_d;
    mod_op_e          s1_op_q, s1_op_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

    logic             s2_valid_q, s2_valid_d;
    logic [W-1:0]     s2_c_q, s2_c_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

    logic             s1_en;
    logic             s2_en;
    logic [W:0]       raw_sum;
    logic [W:0]       raw_dif;
    logic [W:0]       cmp_diff;
    logic             cmp_borrow;
    logic             cmp_diff_unused;
    logic [W-1:0]     add_res;
    logic [W-1:0]     sub_res;

`ifdef MOD_ADDSUB_RANGE_CHK_EN
    logic s1_viol_q, s1_viol_d;
    logic s2_err_q, s2_err_d;
`endif

    assign s2_en   = !s2_valid_q || ready_i;
    assign s1_en   = !s1_valid_q || s2_en;
    assign ready_o = s1_en;

    assign raw_sum = {1'b0, a_i} + {1'b0, b_i};
    assign raw_dif = {1'b0, a_i} - {1'b0, b_i};

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_raw_d   = s1_raw_q;
        s1_mod_d   = s1_mod_q;
        s1_op_d    = s1_op_q;
        s1_tag_d   = s1_tag_q;
        if (s1_en) begin
            s1_valid_d = valid_i;
            if (valid_i) begin
                s1_raw_d = (op_i == MOD_OP_SUB) ? raw_dif : raw_sum;
                s1_mod_d = q_i;
                s1_op_d  = op_i;
                s1_tag_d = tag_i;
            end
        end
    end

    // raw - q decides the add correction; its borrow means raw < q
    subtractor_n #(
        .nb_bit (W + 1)
    ) u_cmp (
        .a_i      (s1_raw_q),
        .b_i      ({1'b0, s1_mod_q}),
        .diff_o   (cmp_diff),
        .borrow_o (cmp_borrow)
    );

    assign cmp_diff_unused = cmp_diff[W];

    always_comb begin
        add_res = cmp_borrow ? s1_raw_q[W-1:0] : cmp_diff[W-1:0];
        sub_res = s1_raw_q[W] ? (s1_raw_q[W-1:0] + s1_mod_q)
                              : s1_raw_q[W-1:0];
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_c_d     = s2_c_q;
        s2_tag_d   = s2_tag_q;
        if (s2_en) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_c_d   = (s1_op_q == MOD_OP_SUB) ? sub_res : add_res;
                s2_tag_d = s1_tag_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            s1_raw_q   <= '0;
            s1_mod_q   <= '0;
            s1_op_q    <= MOD_OP_ADD;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_c_q     <= '0;
            s2_tag_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_raw_q   <= s1_raw_d;
            s1_mod_q   <= s1_mod_d;
            s1_op_q    <= s1_op_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_c_q     <= s2_c_d;
            s2_tag_q   <= s2_tag_d;
        end
    end

`ifdef MOD_ADDSUB_RANGE_CHK_EN
    always_comb begin
        s1_viol_d = s1_viol_q;
        s2_err_d  = s2_err_q;
        if (s1_en && valid_i) begin
            s1_viol_d = (a_i >= q_i) || (b_i >= q_i);
        end
        if (s2_en && s1_valid_q) begin
            s2_err_d = s1_viol_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_viol_q <= 1'b0;
            s2_err_q  <= 1'b0;
        end else begin
            s1_viol_q <= s1_viol_d;
            s2_err_q  <= s2_err_d;
        end
    end

    assign err_o = s2_err_q;
`else
    assign err_o = 1'b0;
`endif

    assign valid_o = s2_valid_q;
    assign c_o     = s2_c_q;
    assign tag_o   = s2_tag_q;

endmodule
